// File: rtl/rom_fetch_ctrl_if.sv
// rom_fetch_ctrl_if: core-side handshake and ROM bus for the program ROM fetch controller.
interface rom_fetch_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int CNTW  = 16
);
  localparam int AW = $clog2(DEPTH);
  logic             start;
  logic [AW-1:0]    start_addr;
  logic             jump;
  logic [AW-1:0]    jump_addr;
  logic             halt;
  logic             ready;
  logic [WIDTH-1:0] din;
  logic             cs_n;
  logic             oe;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] instr;
  logic             valid;
  logic [AW-1:0]    pc_out;
  logic             busy;
  logic [CNTW-1:0]  fetch_cnt;
  modport slave (
    input  start, start_addr, jump, jump_addr, halt, ready, din,
    output cs_n, oe, addr, instr, valid, pc_out, busy, fetch_cnt
  );
  modport master (
    output start, start_addr, jump, jump_addr, halt, ready, din,
    input  cs_n, oe, addr, instr, valid, pc_out, busy, fetch_cnt
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: program ROM reader holding the PC and handing instructions to the core via valid/ready.
module rom_fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int CNTW  = 16
) (
  input logic           clk,
  input logic           rst,
  rom_fetch_ctrl_if.slave fetch_if
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, HOLD} state_e;
  state_e           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]    pc_inc;
  // Explicit wrap keeps non-power-of-two depths correct.
  assign pc_inc = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (fetch_if.start) begin
        pc_d    = fetch_if.start_addr;
        cnt_d   = '0;
        state_d = SELECT;
      end
    end else if (fetch_if.halt) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end else if (fetch_if.jump) begin
      pc_d    = fetch_if.jump_addr;
      valid_d = 1'b0;
      state_d = SELECT;
    end else begin
      case (state_q)
        SELECT: state_d = CAPTURE;
        CAPTURE: begin
          instr_d = fetch_if.din;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        default: if (fetch_if.ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          pc_d    = pc_inc;
          state_d = SELECT;
        end
      endcase
    end
  end
  assign fetch_if.oe        = (state_q == SELECT) || (state_q == CAPTURE);
  assign fetch_if.cs_n      = !fetch_if.oe;
  assign fetch_if.addr      = pc_q;
  assign fetch_if.pc_out    = pc_q;
  assign fetch_if.instr     = instr_q;
  assign fetch_if.valid     = valid_q;
  assign fetch_if.busy      = state_q != IDLE;
  assign fetch_if.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed plan plus random traffic, checked every cycle against a behavioural fetch model.
module tb_rom_fetch_ctrl;
  localparam int WIDTH = 32, DEPTH = 32, CNTW = 16;
  logic clk = 0, rst = 1;
  int n_chk = 0, n_fail = 0;
  logic chk_en = 0;
  logic [WIDTH-1:0] mem [DEPTH];
  rom_fetch_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();
  rom_fetch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (.clk(clk), .rst(rst), .fetch_if(bus));
  always #5 clk = ~clk;
  assign bus.din = mem[bus.addr];
  // Model: running flag, cycles left until the ROM word lands, and the pending-instruction flag.
  bit m_busy = 0, m_valid = 0;
  int m_pc = 0, m_cnt = 0, m_wait = 0;
  logic [WIDTH-1:0] m_instr = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_pc = 0; m_cnt = 0; m_wait = 0; m_instr = 0;
    end else if (!m_busy) begin
      if (bus.start) begin m_busy = 1; m_pc = bus.start_addr; m_cnt = 0; m_wait = 2; end
    end else if (bus.halt) begin
      m_busy = 0; m_valid = 0;
    end else if (bus.jump) begin
      m_pc = bus.jump_addr; m_valid = 0; m_wait = 2;
    end else if (m_valid) begin
      if (bus.ready) begin m_valid = 0; m_cnt = (m_cnt + 1) % (1 << CNTW); m_pc = (m_pc + 1) % DEPTH; m_wait = 2; end
    end else begin
      m_wait--;
      if (m_wait == 0) begin m_valid = 1; m_instr = mem[m_pc]; end
    end
  end
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("m_valid", 64'(bus.valid), 64'(m_valid));
    chk("m_busy", 64'(bus.busy), 64'(m_busy));
    chk("m_pc", 64'(bus.pc_out), 64'(m_pc));
    chk("m_addr", 64'(bus.addr), 64'(m_pc));
    chk("m_instr", 64'(bus.instr), 64'(m_instr));
    chk("m_cnt", 64'(bus.fetch_cnt), 64'(m_cnt));
    chk("m_cs_n", 64'(bus.cs_n), 64'(!(m_busy && !m_valid)));
    chk("m_oe", 64'(bus.oe), 64'(m_busy && !m_valid));
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'hA000_0000 + k;
    {bus.start, bus.jump, bus.halt, bus.ready} = '0;
    bus.start_addr = 0; bus.jump_addr = 0;
    tick(2);
    chk_en = 1;
    rst = 0;
    bus.start = 1; bus.ready = 1;
    tick(1); bus.start = 0;
    chk("seq_sel_cs", 64'(bus.cs_n), 0);
    tick(2);
    chk("seq_i0", 64'(bus.instr), 64'hA000_0000); chk("seq_v0", 64'(bus.valid), 1); chk("seq_hold_cs", 64'(bus.cs_n), 1);
    tick(3);
    chk("seq_i1", 64'(bus.instr), 64'hA000_0001); chk("seq_pc1", 64'(bus.pc_out), 1);
    tick(3);
    chk("seq_i2", 64'(bus.instr), 64'hA000_0002); chk("seq_pc2", 64'(bus.pc_out), 2);
    tick(1);
    chk("seq_cnt3", 64'(bus.fetch_cnt), 3); chk("seq_v_drop", 64'(bus.valid), 0);
    tick(5);
    bus.ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_instr", 64'(bus.instr), 64'hA000_0004);
      chk("stall_valid", 64'(bus.valid), 1);
      chk("stall_cs", 64'(bus.cs_n), 1);
    end
    bus.ready = 1;
    tick(1);
    chk("stall_cnt", 64'(bus.fetch_cnt), 5);
    tick(2);
    chk("stall_next", 64'(bus.instr), 64'hA000_0005);
    bus.halt = 1; tick(1); bus.halt = 0;
    chk("halt_busy", 64'(bus.busy), 0); chk("halt_pc", 64'(bus.pc_out), 5); chk("halt_cnt", 64'(bus.fetch_cnt), 5);
    bus.start = 1; bus.start_addr = 30;
    tick(1); bus.start = 0;
    tick(2);
    chk("wrap_i30", 64'(bus.instr), 64'hA000_001E);
    bus.start = 1; bus.start_addr = 7;
    tick(1); bus.start = 0;
    chk("busy_start_ign", 64'(bus.pc_out), 31);
    tick(2);
    chk("wrap_i31", 64'(bus.instr), 64'hA000_001F);
    tick(3);
    chk("wrap_pc0", 64'(bus.pc_out), 0); chk("wrap_i0", 64'(bus.instr), 64'hA000_0000);
    tick(3);
    chk("wrap_pc1", 64'(bus.pc_out), 1);
    tick(2);
    bus.jump = 1; bus.jump_addr = 20;
    tick(1); bus.jump = 0;
    chk("jcap_pc", 64'(bus.pc_out), 20); chk("jcap_v", 64'(bus.valid), 0);
    tick(2);
    chk("jcap_i20", 64'(bus.instr), 64'hA000_0014); chk("jcap_cnt", 64'(bus.fetch_cnt), 4);
    bus.jump = 1; bus.jump_addr = 10;
    tick(1); bus.jump = 0;
    chk("jhold_pc", 64'(bus.pc_out), 10); chk("jhold_cnt", 64'(bus.fetch_cnt), 4);
    tick(2);
    chk("jhold_i10", 64'(bus.instr), 64'hA000_000A);
    bus.halt = 1; bus.jump = 1; bus.jump_addr = 25;
    tick(1); bus.halt = 0; bus.jump = 0;
    chk("hj_busy", 64'(bus.busy), 0); chk("hj_pc", 64'(bus.pc_out), 10); chk("hj_instr_kept", 64'(bus.instr), 64'hA000_000A);
    bus.ready = 0; bus.start = 1; bus.start_addr = 3;
    tick(1); bus.start = 0;
    tick(2);
    chk("rst_pre_v", 64'(bus.valid), 1);
    rst = 1; tick(2); rst = 0;
    chk("rst_v", 64'(bus.valid), 0); chk("rst_cs", 64'(bus.cs_n), 1); chk("rst_oe", 64'(bus.oe), 0);
    chk("rst_pc", 64'(bus.pc_out), 0); chk("rst_cnt", 64'(bus.fetch_cnt), 0); chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_instr", 64'(bus.instr), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(299) == 0;
      bus.start = $urandom_range(3) == 0;
      bus.halt = $urandom_range(40) == 0;
      bus.jump = $urandom_range(15) == 0;
      bus.ready = $urandom_range(1);
      bus.start_addr = 5'($urandom_range(DEPTH - 1));
      bus.jump_addr = 5'($urandom_range(DEPTH - 1));
      tick(1);
    end
    rst = 0;
    tick(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
- Initiator/reader for the program ROM: drives the ROM's CS_ (active-low), OE (active-high) and ADDR, and captures its combinational DOUT.
- Holds the program counter (PC). Presents each fetched instruction to the core through a VALID/READY handshake.
- Supports start at an address, jump redirect, abort/halt, PC wrap-around, and an accepted-instruction counter.
- Sits between the program ROM and the instruction decode stage.

Parameters:
- WIDTH, 32, instruction/data width; matches ROM WIDTH.
- DEPTH, 32, ROM word count; address width AW = $clog2(DEPTH).
- CNTW, 16, width of the accepted-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  in IDLE: load PC from START_ADDR and begin fetching.
- START_ADDR  input  AW  first fetch address.
- JUMP  input  1  redirect request.
- JUMP_ADDR  input  AW  redirect target.
- HALT  input  1  abort fetching and return to IDLE.
- READY  input  1  core accepts INSTR this cycle.
- DIN  input  WIDTH  ROM DOUT.
- CS_  output  1  ROM chip select, active-low.
- OE  output  1  ROM output enable, active-high.
- ADDR  output  AW  ROM address; always equals PC.
- INSTR  output  WIDTH  captured instruction, registered.
- VALID  output  1  INSTR holds an unconsumed instruction.
- PC_OUT  output  AW  address of the instruction currently in INSTR or in flight.
- BUSY  output  1  high in any state other than IDLE.
- FETCH_CNT  output  CNTW  count of accepted instructions (VALID & READY).

Behaviour:
- Reset values, state = IDLE: PC = 0, INSTR = 0, VALID = 0, FETCH_CNT = 0, CS_ = 1, OE = 0, ADDR = 0, BUSY = 0.
- Output decoding:
  - CS_ and OE are Moore outputs decoded from the state register only.
  - CS_ = 0 and OE = 1 in SELECT and CAPTURE; CS_ = 1 and OE = 0 in IDLE and HOLD.
- States and transitions:
  - IDLE: if START, then PC <= START_ADDR, FETCH_CNT <= 0, next state SELECT. JUMP and READY are ignored in IDLE.
  - SELECT: one cycle for ROM address setup. Next state CAPTURE.
  - CAPTURE: INSTR <= DIN, VALID <= 1, next state HOLD.
  - HOLD: VALID = 1 and INSTR is stable. If READY: VALID <= 0, FETCH_CNT <= FETCH_CNT + 1, PC <= PC + 1, next state SELECT. If not READY: remain in HOLD, all outputs unchanged.
- Priority each cycle: RST > HALT > JUMP > READY handshake > START.
- HALT in any non-IDLE state:
  - Next state IDLE, VALID <= 0.
  - PC and FETCH_CNT are held. A HOLD instruction is discarded and not counted.
  - HALT in IDLE has no effect.
- JUMP in SELECT, CAPTURE or HOLD:
  - PC <= JUMP_ADDR, VALID <= 0, next state SELECT.
  - An instruction pending in HOLD is squashed and not counted, even if READY is high.
  - JUMP in CAPTURE suppresses the INSTR/VALID update.
- START outside IDLE is ignored.
- Latency: first VALID rises 3 cycles after the START edge (IDLE, SELECT, CAPTURE, then VALID in HOLD). With READY held high, steady-state throughput is one instruction per 3 cycles.
- PC wrap: PC + 1 is computed modulo DEPTH, so 31 -> 0 for DEPTH = 32.
- FETCH_CNT wraps modulo 2^CNTW.
- INSTR holds its last value when VALID = 0. It changes only in CAPTURE.
- RST asserted mid-fetch (any state) forces all reset values on the next edge. VALID drops without a handshake.

Test Plan:
- Reset: assert RST for 2 cycles in HOLD with VALID = 1 -> next cycle VALID = 0, CS_ = 1, OE = 0, PC_OUT = 0, FETCH_CNT = 0, BUSY = 0.
- Sequential fetch: ROM model with MEM[k] = 32'hA000_0000 + k, START with START_ADDR = 0, READY = 1 -> VALID pulses every 3rd cycle, INSTR = A0000000, A0000001, A0000002 at PC_OUT 0, 1, 2; FETCH_CNT = 3 after the third accept; CS_ low exactly in SELECT/CAPTURE cycles.
- Stall: READY = 0 for 5 cycles while in HOLD at PC 4 -> INSTR = A0000004 and VALID = 1 remain stable, CS_ = 1; READY = 1 -> accept, then the next VALID shows A0000005 three cycles later.
- Wrap: START_ADDR = 30, READY = 1 -> fetch order 30, 31, 0, 1; PC_OUT wraps to 0.
- Jump: at PC 2 assert JUMP with JUMP_ADDR = 20 during CAPTURE -> no VALID for PC 2, next VALID shows A0000014 at PC_OUT 20, FETCH_CNT not incremented for PC 2. Repeat with JUMP and READY both high in HOLD -> pending instruction squashed and not counted.
- Halt/START interplay: START while BUSY -> ignored (PC unchanged). HALT in HOLD -> IDLE next cycle, VALID = 0, PC held. HALT and JUMP in the same cycle -> IDLE, PC not loaded from JUMP_ADDR.
